// File: rtl/bitbang_pkg.sv
// Shared types for the bit-bang sequencer: FSM state and queued command.
// Command fields are sized for up to CMD_IO_MAX pins and CMD_HOLD_MAX hold bits.
package bitbang_pkg;

    localparam int CMD_IO_MAX   = 32;
    localparam int CMD_HOLD_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_HOLD,
        ST_SAMPLE
    } state_t;

    typedef struct packed {
        logic [CMD_IO_MAX-1:0]   dir;
        logic [CMD_IO_MAX-1:0]   outval;
        logic [CMD_HOLD_MAX-1:0] hold;
        logic                    sample;
    } cmd_t;

endpackage

// File: rtl/bitbang_sequencer_if.sv
// Command and response handshakes of the bit-bang sequencer.
// master = command producer / response consumer, slave = sequencer.
interface bitbang_sequencer_if #(
    parameter int IO_NUM_OF = 10,
    parameter int HOLD_W    = 8
);
    logic                 in_cmd_valid;
    logic                 out_cmd_ready;
    logic [IO_NUM_OF-1:0] in_cmd_dir;
    logic [IO_NUM_OF-1:0] in_cmd_outval;
    logic [HOLD_W-1:0]    in_cmd_hold;
    logic                 in_cmd_sample;
    logic                 out_rsp_valid;
    logic                 in_rsp_ready;
    logic [IO_NUM_OF-1:0] out_rsp_data;

    modport master (
        output in_cmd_valid, in_cmd_dir, in_cmd_outval,
        output in_cmd_hold, in_cmd_sample, in_rsp_ready,
        input  out_cmd_ready, out_rsp_valid, out_rsp_data
    );

    modport slave (
        input  in_cmd_valid, in_cmd_dir, in_cmd_outval,
        input  in_cmd_hold, in_cmd_sample, in_rsp_ready,
        output out_cmd_ready, out_rsp_valid, out_rsp_data
    );
endinterface

// File: rtl/bitbang_cmd_fifo.sv
// Command FIFO; pointers carry an extra wrap bit to tell full from empty.
// A push while full is taken when a pop happens in the same cycle.
module bitbang_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/bitbang_sequencer.sv
// Bit-bang sequencer: queued pin patterns held for a count, optional sampling.
// Define BITBANG_SEQ_SYNC_EN to pass in_io_pins through a 2-flop synchronizer.
import bitbang_pkg::*;

module bitbang_sequencer #(
    parameter int IO_NUM_OF = 10,
    parameter int HOLD_W    = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    bitbang_sequencer_if.slave   bus,
    output logic [IO_NUM_OF-1:0] out_io_direction,
    output logic [IO_NUM_OF-1:0] out_io_outval,
    input  logic [IO_NUM_OF-1:0] in_io_pins,
    output logic                 out_busy
);
    state_t               state;
    cmd_t                 push_cmd;
    cmd_t                 head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [HOLD_W-1:0]    cnt;
    logic [HOLD_W-1:0]    hold_in;
    logic [HOLD_W-1:0]    hold_ld;
    logic                 smp;
    logic                 hold_done;
    logic                 cap_ok;
    logic                 capture;
    logic                 chain;
    logic [IO_NUM_OF-1:0] io_dir;
    logic [IO_NUM_OF-1:0] io_val;
    logic                 rsp_valid;
    logic [IO_NUM_OF-1:0] rsp_data;
    logic [IO_NUM_OF-1:0] pins_s;

`ifdef BITBANG_SEQ_SYNC_EN
    logic [IO_NUM_OF-1:0] sync1;
    logic [IO_NUM_OF-1:0] sync2;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_io_pins;
            sync2 <= sync1;
        end
    end
    assign pins_s = sync2;
`else
    assign pins_s = in_io_pins;
`endif

    always_comb begin
        push_cmd        = '0;
        push_cmd.dir    = CMD_IO_MAX'(bus.in_cmd_dir);
        push_cmd.outval = CMD_IO_MAX'(bus.in_cmd_outval);
        push_cmd.hold   = CMD_HOLD_MAX'(bus.in_cmd_hold);
        push_cmd.sample = bus.in_cmd_sample;
    end

    assign push = bus.in_cmd_valid && !full;

    bitbang_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign hold_in   = HOLD_W'(head.hold);
    assign hold_ld   = (hold_in == '0) ? HOLD_W'(1) : hold_in;
    assign hold_done = (state == ST_HOLD) && (cnt == HOLD_W'(1));
    assign cap_ok    = !rsp_valid || bus.in_rsp_ready;
    assign capture   = (state == ST_SAMPLE) && cap_ok;
    // Leaving HOLD/SAMPLE with work queued applies it on the same edge,
    // so consecutive patterns sit exactly their hold count apart.
    assign chain     = (hold_done && !smp) || capture;
    assign pop       = (state == ST_APPLY) || (chain && !empty);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            smp       <= 1'b0;
            io_dir    <= '0;
            io_val    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= pins_s;
            end else if (bus.in_rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (pop) begin
                io_dir <= IO_NUM_OF'(head.dir);
                io_val <= IO_NUM_OF'(head.outval);
                cnt    <= hold_ld;
                smp    <= head.sample;
            end
            unique case (state)
                ST_IDLE:   if (!empty) state <= ST_APPLY;
                ST_APPLY:  state <= ST_HOLD;
                ST_HOLD: begin
                    if (hold_done) begin
                        if (smp)        state <= ST_SAMPLE;
                        else if (empty) state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SAMPLE: if (cap_ok) state <= empty ? ST_IDLE : ST_HOLD;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign out_io_direction  = io_dir;
    assign out_io_outval     = io_val;
    assign out_busy          = (state != ST_IDLE) || !empty;
    assign bus.out_cmd_ready = !full;
    assign bus.out_rsp_valid = rsp_valid;
    assign bus.out_rsp_data  = rsp_data;
endmodule

// File: tb/tb_bitbang_sequencer.sv
// Directed bench for bitbang_sequencer: reset, timing, fill, backpressure,
// mid-hold reset and pin sampling (follows BITBANG_SEQ_SYNC_EN if defined).
module tb_bitbang_sequencer;
    logic       in_clk;
    logic       in_rst_n;
    logic [9:0] out_io_direction;
    logic [9:0] out_io_outval;
    logic [9:0] in_io_pins;
    logic       out_busy;
    int         n_chk;
    int         n_bad;
    logic       pre;

    bitbang_sequencer_if #(.IO_NUM_OF(10), .HOLD_W(8)) bus ();

    bitbang_sequencer #(
        .IO_NUM_OF (10),
        .HOLD_W    (8),
        .CMD_DEPTH (4)
    ) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .bus              (bus.slave),
        .out_io_direction (out_io_direction),
        .out_io_outval    (out_io_outval),
        .in_io_pins       (in_io_pins),
        .out_busy         (out_busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input logic [9:0] dir, input logic [9:0] val,
                        input logic [7:0] hold, input logic smp);
        bus.in_cmd_dir    = dir;
        bus.in_cmd_outval = val;
        bus.in_cmd_hold   = hold;
        bus.in_cmd_sample = smp;
        bus.in_cmd_valid  = 1'b1;
        for (int i = 0; i < 60 && !bus.out_cmd_ready; i++) tick();
        if (!bus.out_cmd_ready) chk("push_timeout", 0, 1);
        tick();
        bus.in_cmd_valid = 1'b0;
    endtask

    task automatic consume();
        bus.in_rsp_ready = 1'b1;
        tick();
        bus.in_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        in_rst_n = 1'b0;
        in_io_pins = '0;
        bus.in_cmd_valid = 1'b0;
        bus.in_cmd_dir = '0;
        bus.in_cmd_outval = '0;
        bus.in_cmd_hold = '0;
        bus.in_cmd_sample = 1'b0;
        bus.in_rsp_ready = 1'b0;
        repeat (3) tick();
        in_rst_n = 1'b1;
        tick();

        chk("rst_dir", out_io_direction, 10'h000);
        chk("rst_val", out_io_outval, 10'h000);
        chk("rst_ready", bus.out_cmd_ready, 1);
        chk("rst_busy", out_busy, 0);
        chk("rst_rspv", bus.out_rsp_valid, 0);
        chk("rst_rspd", bus.out_rsp_data, 10'h000);

        // single sampling command, hold 3
        in_io_pins = 10'h2AB;
        push(10'h3FF, 10'h155, 8'd3, 1'b1);
        chk("one_busy", out_busy, 1);
        tick();
        chk("one_pre_dir", out_io_direction, 10'h000);
        tick();
        chk("one_dir", out_io_direction, 10'h3FF);
        chk("one_val", out_io_outval, 10'h155);
        tick();
        tick();
        chk("one_hold_dir", out_io_direction, 10'h3FF);
        tick();
        chk("one_samp_rspv", bus.out_rsp_valid, 0);
        chk("one_samp_dir", out_io_direction, 10'h3FF);
        tick();
        chk("one_rspv", bus.out_rsp_valid, 1);
        chk("one_rspd", bus.out_rsp_data, 10'h2AB);
        chk("one_idle", out_busy, 0);
        chk("one_keep_dir", out_io_direction, 10'h3FF);
        consume();
        chk("one_consumed", bus.out_rsp_valid, 0);

        // pin toggles during the last hold cycle
        in_io_pins = 10'h0AA;
        push(10'h001, 10'h001, 8'd2, 1'b1);
        repeat (3) tick();
        in_io_pins = 10'h155;
        tick();
        tick();
        chk("sync_rspv", bus.out_rsp_valid, 1);
`ifdef BITBANG_SEQ_SYNC_EN
        chk("sync_rspd", bus.out_rsp_data, 10'h0AA);
`else
        chk("sync_rspd", bus.out_rsp_data, 10'h155);
`endif
        consume();

        // backpressure across two sampling commands
        in_io_pins = 10'h00F;
        push(10'h010, 10'h000, 8'd1, 1'b1);
        push(10'h020, 10'h000, 8'd1, 1'b1);
        for (int i = 0; i < 20 && !bus.out_rsp_valid; i++) tick();
        chk("bp_first_v", bus.out_rsp_valid, 1);
        chk("bp_first_d", bus.out_rsp_data, 10'h00F);
        in_io_pins = 10'h0F0;
        repeat (6) tick();
        chk("bp_stall_d", bus.out_rsp_data, 10'h00F);
        chk("bp_stall_busy", out_busy, 1);
        chk("bp_stall_dir", out_io_direction, 10'h020);
        consume();
        chk("bp_second_v", bus.out_rsp_valid, 1);
        chk("bp_second_d", bus.out_rsp_data, 10'h0F0);
        tick();
        chk("bp_idle", out_busy, 0);
        consume();
        chk("bp_drained", bus.out_rsp_valid, 0);

        // fill behind a long blocker, then hold-0 patterns back to back
        push(10'h100, 10'h000, 8'd20, 1'b0);
        push(10'h001, 10'h001, 8'd0, 1'b0);
        push(10'h002, 10'h002, 8'd0, 1'b0);
        push(10'h004, 10'h004, 8'd0, 1'b0);
        push(10'h008, 10'h008, 8'd0, 1'b0);
        chk("fill_ready", bus.out_cmd_ready, 0);
        chk("fill_busy", out_busy, 1);
        bus.in_cmd_dir = 10'h010;
        bus.in_cmd_outval = 10'h010;
        bus.in_cmd_hold = 8'd0;
        bus.in_cmd_sample = 1'b0;
        bus.in_cmd_valid = 1'b1;
        for (int i = 0; i < 40 && out_io_direction != 10'h001; i++) begin
            pre = bus.in_cmd_valid && bus.out_cmd_ready;
            tick();
            if (pre) bus.in_cmd_valid = 1'b0;
        end
        chk("fill_p1", out_io_direction, 10'h001);
        chk("fill_ready_back", bus.out_cmd_ready, 1);
        pre = bus.in_cmd_valid && bus.out_cmd_ready;
        tick();
        if (pre) bus.in_cmd_valid = 1'b0;
        chk("fill_p2", out_io_direction, 10'h002);
        chk("fill_pushed", bus.in_cmd_valid, 0);
        tick();
        chk("fill_p3", out_io_direction, 10'h004);
        tick();
        chk("fill_p4", out_io_direction, 10'h008);
        tick();
        chk("fill_p5", out_io_direction, 10'h010);
        chk("fill_p5_val", out_io_outval, 10'h010);
        bus.in_cmd_valid = 1'b0;
        tick();
        chk("fill_idle", out_busy, 0);
        chk("fill_keep", out_io_direction, 10'h010);

        // reset in the middle of a long hold
        push(10'h3F0, 10'h0F0, 8'd200, 1'b0);
        push(10'h00F, 10'h00F, 8'd5, 1'b0);
        repeat (8) tick();
        chk("mid_dir", out_io_direction, 10'h3F0);
        in_rst_n = 1'b0;
        #1;
        chk("mid_rst_dir", out_io_direction, 10'h000);
        chk("mid_rst_val", out_io_outval, 10'h000);
        chk("mid_rst_ready", bus.out_cmd_ready, 1);
        chk("mid_rst_busy", out_busy, 0);
        tick();
        in_rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_after_busy", out_busy, 0);
        chk("mid_after_dir", out_io_direction, 10'h000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
